ddr2_ui_arbiter: RTL and testbench

Two-client arbiter in front of the DDR2 memory-controller user interface: address FIFO (`app_af`), write-data FIFO (`app_wdf`) and read-data return. Accepts one read or write burst request per client, picks a winner by round-robin and drives the command and write data onto the controller. It tracks outstanding reads so each returned 128-bit beat is routed to the client that issued it. Sits between the controller wrapper and the application clients, replacing any single-client UI sequencer.

---
 rtl/ddr2_arb_pkg.sv | 22 ++
 rtl/rd_tag_fifo.sv | 58 +++++
 rtl/ddr2_ui_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_ddr2_ui_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared constants for the two-client DDR2 UI arbiter: command codes,
// FSM encoding and the bit layout of the debug status byte.
package ddr2_arb_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_B1 = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam int DBG_STATE_LO = 0;
    localparam int DBG_STATE_HI = 1;
    localparam int DBG_RR       = 2;
    localparam int DBG_FULL     = 3;
    localparam int DBG_EMPTY    = 4;
    localparam int DBG_BP       = 5;
    localparam int DBG_ORPHAN   = 7;

endpackage

// File: rtl/rd_tag_fifo.sv
// One-bit-wide tag FIFO recording which client issued each outstanding read.
// Push is ignored when full and pop is ignored when empty.
module rd_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr2_ui_arbiter.sv
// Round-robin arbiter for two clients in front of the DDR2 controller UI.
// Issues one burst per grant and steers returned read beats by issue order.
module ddr2_ui_arbiter #(
    parameter int ADDR_W    = 31,
    parameter int DATA_W    = 128,
    parameter int TAG_DEPTH = 16
) (
    input  logic                clk0_tb,
    input  logic                rst0_tb,
    input  logic                phy_init_done,
    input  logic                app_af_afull,
    input  logic                app_wdf_afull,
    input  logic                rd_data_valid,
    input  logic [DATA_W-1:0]   rd_data_fifo_out,
    output logic [2:0]          cmd,
    output logic [ADDR_W-1:0]   address,
    output logic                af_we,
    output logic                wdf_we,
    output logic [DATA_W-1:0]   w_data,
    input  logic                c0_req,
    input  logic                c0_rnw,
    input  logic [ADDR_W-1:0]   c0_addr,
    input  logic [2*DATA_W-1:0] c0_wdata,
    output logic                c0_ack,
    output logic                c0_rvalid,
    output logic [DATA_W-1:0]   c0_rdata,
    input  logic                c1_req,
    input  logic                c1_rnw,
    input  logic [ADDR_W-1:0]   c1_addr,
    input  logic [2*DATA_W-1:0] c1_wdata,
    output logic                c1_ack,
    output logic                c1_rvalid,
    output logic [DATA_W-1:0]   c1_rdata,
    output logic [7:0]          debug
);

    import ddr2_arb_pkg::*;

    // Client handshake: a client raises req with rnw/addr/wdata and holds them
    // stable until it sees its one-cycle ack; in that ack cycle it may drop or
    // change the request. The GAP state means the changed request is always the
    // one sampled next, so a held req is simply treated as a new request.

    arb_state_t state, state_next;
    logic       rr, rr_next;

    logic              elig0, elig1, grant, win, win_rnw;
    logic [ADDR_W-1:0] win_addr;
    logic [2*DATA_W-1:0] win_wdata;

    logic [DATA_W-1:0] beat1_q, beat1_d;
    logic [2:0]        cmd_d;
    logic [ADDR_W-1:0] address_d;
    logic              af_we_d, wdf_we_d, ack0_d, ack1_d;
    logic [DATA_W-1:0] w_data_d;

    logic tag_push, tag_pop, tag_head, tag_full, tag_empty;
    logic bp, orphan_err;
    logic [7:0] debug_d;

    always_comb begin
        elig0 = 1'b0;
        elig1 = 1'b0;
        if (state == ST_IDLE && phy_init_done && !app_af_afull) begin
            elig0 = c0_req && (c0_rnw ? !tag_full : !app_wdf_afull);
            elig1 = c1_req && (c1_rnw ? !tag_full : !app_wdf_afull);
        end
    end

    assign grant     = elig0 || elig1;
    assign win       = (elig0 && elig1) ? rr : elig1;
    assign win_rnw   = win ? c1_rnw : c0_rnw;
    assign win_addr  = win ? c1_addr : c0_addr;
    assign win_wdata = win ? c1_wdata : c0_wdata;
    assign tag_push  = grant && win_rnw;

    always_comb begin
        state_next = state;
        rr_next    = rr;
        beat1_d    = beat1_q;
        cmd_d      = 3'b000;
        address_d  = '0;
        af_we_d    = 1'b0;
        wdf_we_d   = 1'b0;
        w_data_d   = '0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    rr_next   = ~win;
                    af_we_d   = 1'b1;
                    address_d = win_addr;
                    ack0_d    = !win;
                    ack1_d    = win;
                    if (win_rnw) begin
                        cmd_d      = CMD_READ;
                        state_next = ST_GAP;
                    end else begin
                        cmd_d      = CMD_WRITE;
                        wdf_we_d   = 1'b1;
                        w_data_d   = win_wdata[DATA_W-1:0];
                        beat1_d    = win_wdata[2*DATA_W-1:DATA_W];
                        state_next = ST_WR_B1;
                    end
                end
            end
            ST_WR_B1: begin
                cmd_d      = CMD_WRITE;
                address_d  = address;
                wdf_we_d   = 1'b1;
                w_data_d   = beat1_q;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk0_tb or posedge rst0_tb) begin
        if (rst0_tb) begin
            state   <= ST_IDLE;
            rr      <= 1'b0;
            beat1_q <= '0;
            cmd     <= 3'b000;
            address <= '0;
            af_we   <= 1'b0;
            wdf_we  <= 1'b0;
            w_data  <= '0;
            c0_ack  <= 1'b0;
            c1_ack  <= 1'b0;
        end else begin
            state   <= state_next;
            rr      <= rr_next;
            beat1_q <= beat1_d;
            cmd     <= cmd_d;
            address <= address_d;
            af_we   <= af_we_d;
            wdf_we  <= wdf_we_d;
            w_data  <= w_data_d;
            c0_ack  <= ack0_d;
            c1_ack  <= ack1_d;
        end
    end

    // The tag is released only after the second beat of the burst.
    assign tag_pop = rd_data_valid && !tag_empty && bp;

    rd_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk0_tb),
        .rst       (rst0_tb),
        .push      (tag_push),
        .push_data (win),
        .pop       (tag_pop),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    always_ff @(posedge clk0_tb or posedge rst0_tb) begin
        if (rst0_tb) begin
            c0_rvalid  <= 1'b0;
            c1_rvalid  <= 1'b0;
            c0_rdata   <= '0;
            c1_rdata   <= '0;
            bp         <= 1'b0;
            orphan_err <= 1'b0;
        end else begin
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;
            if (rd_data_valid) begin
                if (tag_empty) begin
                    orphan_err <= 1'b1;
                end else begin
                    bp <= ~bp;
                    if (tag_head) begin
                        c1_rvalid <= 1'b1;
                        c1_rdata  <= rd_data_fifo_out;
                    end else begin
                        c0_rvalid <= 1'b1;
                        c0_rdata  <= rd_data_fifo_out;
                    end
                end
            end
        end
    end

    always_comb begin
        debug_d = '0;
        debug_d[DBG_STATE_HI:DBG_STATE_LO] = state;
        debug_d[DBG_RR]     = rr;
        debug_d[DBG_FULL]   = tag_full;
        debug_d[DBG_EMPTY]  = tag_empty;
        debug_d[DBG_BP]     = bp;
        debug_d[DBG_ORPHAN] = orphan_err;
    end

    // Registered status, so it reads all-zero in reset and trails by a cycle.
    always_ff @(posedge clk0_tb or posedge rst0_tb) begin
        if (rst0_tb) begin
            debug <= '0;
        end else begin
            debug <= debug_d;
        end
    end

endmodule

// File: tb/tb_ddr2_ui_arbiter.sv
// Directed self-checking bench for ddr2_ui_arbiter: grants, round-robin,
// read steering, tag-full back-pressure, write afull, orphan data and reset.
module tb_ddr2_ui_arbiter;

    localparam int ADDR_W    = 31;
    localparam int DATA_W    = 128;
    localparam int TAG_DEPTH = 16;

    logic                clk0_tb = 1'b0;
    logic                rst0_tb = 1'b1;
    logic                phy_init_done = 1'b0;
    logic                app_af_afull = 1'b0;
    logic                app_wdf_afull = 1'b0;
    logic                rd_data_valid = 1'b0;
    logic [DATA_W-1:0]   rd_data_fifo_out = '0;
    logic [2:0]          cmd;
    logic [ADDR_W-1:0]   address;
    logic                af_we, wdf_we;
    logic [DATA_W-1:0]   w_data;
    logic                c0_req = 1'b0, c0_rnw = 1'b0;
    logic [ADDR_W-1:0]   c0_addr = '0;
    logic [2*DATA_W-1:0] c0_wdata = '0;
    logic                c0_ack, c0_rvalid;
    logic [DATA_W-1:0]   c0_rdata;
    logic                c1_req = 1'b0, c1_rnw = 1'b0;
    logic [ADDR_W-1:0]   c1_addr = '0;
    logic [2*DATA_W-1:0] c1_wdata = '0;
    logic                c1_ack, c1_rvalid;
    logic [DATA_W-1:0]   c1_rdata;
    logic [7:0]          debug;

    int errors = 0;
    int checks = 0;

    ddr2_ui_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk0_tb(clk0_tb), .rst0_tb(rst0_tb), .phy_init_done(phy_init_done),
        .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
        .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out),
        .cmd(cmd), .address(address), .af_we(af_we), .wdf_we(wdf_we), .w_data(w_data),
        .c0_req(c0_req), .c0_rnw(c0_rnw), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_ack(c0_ack), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_rnw(c1_rnw), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_ack(c1_ack), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .debug(debug)
    );

    always #5 clk0_tb = ~clk0_tb;

    task automatic wait_ack(input int limit, output bit found, output bit who, output int cycles);
        found = 1'b0;
        who = 1'b0;
        cycles = 0;
        while (!found && cycles < limit) begin
            @(negedge clk0_tb);
            cycles++;
            if (c0_ack === 1'b1) begin
                found = 1'b1;
                who = 1'b0;
            end else if (c1_ack === 1'b1) begin
                found = 1'b1;
                who = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(negedge clk0_tb);
        checks++;
        if ({cmd, address, af_we, wdf_we, w_data, c0_ack, c1_ack, c0_rvalid, c1_rvalid,
             c0_rdata, c1_rdata, debug} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cmd=%0h af_we=%0b wdf_we=%0b debug=%0h required all 0",
                     cmd, af_we, wdf_we, debug);
        end
        rst0_tb = 1'b0;
        c0_req = 1'b1;
        c0_rnw = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk0_tb);
            if (c0_ack === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL no_grant_before_init: acks=%0d required 0", n);
        end
        checks++;
        if (debug !== 8'h10) begin
            errors++;
            $display("FAIL debug_idle: debug=%0h required 10", debug);
        end
        c0_req = 1'b0;
        phy_init_done = 1'b1;
        @(negedge clk0_tb);
    endtask

    task automatic test_write();
        c0_req = 1'b1;
        c0_rnw = 1'b0;
        c0_addr = ADDR_W'(90000);
        c0_wdata = {DATA_W'(2), DATA_W'(1)};
        @(negedge clk0_tb);
        checks++;
        if ({af_we, wdf_we, c0_ack, c1_ack} !== 4'b1110 || w_data !== DATA_W'(1) ||
            cmd !== 3'b000 || address !== ADDR_W'(90000)) begin
            errors++;
            $display("FAIL write_beat0: af_we=%0b wdf_we=%0b ack=%0b%0b w_data=%0h cmd=%0h addr=%0d required 1 1 10 1 0 90000",
                     af_we, wdf_we, c0_ack, c1_ack, w_data, cmd, address);
        end
        c0_req = 1'b0;
        @(negedge clk0_tb);
        checks++;
        if ({af_we, wdf_we, c0_ack} !== 3'b010 || w_data !== DATA_W'(2)) begin
            errors++;
            $display("FAIL write_beat1: af_we=%0b wdf_we=%0b ack=%0b w_data=%0h required 0 1 0 2",
                     af_we, wdf_we, c0_ack, w_data);
        end
        @(negedge clk0_tb);
        checks++;
        if ({af_we, wdf_we, c0_ack, c1_ack} !== 4'b0000 || cmd !== 3'b000) begin
            errors++;
            $display("FAIL write_gap: af_we=%0b wdf_we=%0b cmd=%0h required 0 0 0", af_we, wdf_we, cmd);
        end
        @(negedge clk0_tb);
        checks++;
        if (debug[2:0] !== 3'b100) begin
            errors++;
            $display("FAIL write_rr: debug[2:0]=%0b required 100", debug[2:0]);
        end
    endtask

    task automatic test_read_rr();
        logic [3:0] exp_order = 4'b0101;
        bit found, who;
        int cyc;
        c0_req = 1'b1; c0_rnw = 1'b1; c0_addr = ADDR_W'(90000);
        c1_req = 1'b1; c1_rnw = 1'b1; c1_addr = ADDR_W'(90001);
        for (int i = 0; i < 4; i++) begin
            wait_ack(10, found, who, cyc);
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL rr_timeout: grant %0d not seen, required within 10 cycles", i);
            end else begin
                checks++;
                if (who !== exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order: grant %0d to c%0d required c%0d", i, who, exp_order[i]);
                end
                checks++;
                if (cmd !== 3'b001 || af_we !== 1'b1 || wdf_we !== 1'b0 ||
                    address !== (exp_order[i] ? ADDR_W'(90001) : ADDR_W'(90000))) begin
                    errors++;
                    $display("FAIL rr_cmd: cmd=%0h af_we=%0b wdf_we=%0b addr=%0d for grant %0d",
                             cmd, af_we, wdf_we, address, i);
                end
                if (i > 0) begin
                    checks++;
                    if (cyc !== 2) begin
                        errors++;
                        $display("FAIL rr_spacing: %0d cycles required 2", cyc);
                    end
                end
            end
            if (i == 3) begin
                c0_req = 1'b0;
                c1_req = 1'b0;
            end
        end
        @(negedge clk0_tb);
    endtask

    task automatic test_read_return();
        logic [3:0] dest = 4'b0101;
        logic exp_c;
        for (int k = 1; k <= 8; k++) begin
            rd_data_valid = 1'b1;
            rd_data_fifo_out = DATA_W'(k);
            @(negedge clk0_tb);
            exp_c = dest[(k-1)/2];
            checks++;
            if ({c1_rvalid, c0_rvalid} !== (exp_c ? 2'b10 : 2'b01) ||
                (exp_c ? c1_rdata : c0_rdata) !== DATA_W'(k)) begin
                errors++;
                $display("FAIL return_route: beat %0d rvalid c1c0=%0b%0b rdata=%0h/%0h required c%0d data %0d",
                         k, c1_rvalid, c0_rvalid, c1_rdata, c0_rdata, exp_c, k);
            end
        end
        rd_data_valid = 1'b0;
        @(negedge clk0_tb);
        checks++;
        if ({c1_rvalid, c0_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL return_idle: rvalid c1c0=%0b%0b required 00", c1_rvalid, c0_rvalid);
        end
        @(negedge clk0_tb);
        checks++;
        if (debug[4:3] !== 2'b10 || debug[5] !== 1'b0) begin
            errors++;
            $display("FAIL return_empty: debug=%0h required empty set, full and bp clear", debug);
        end
    endtask

    task automatic test_tag_full();
        bit found, who;
        int cyc, n;
        c0_req = 1'b1; c0_rnw = 1'b1; c0_addr = ADDR_W'(256);
        for (int i = 0; i < TAG_DEPTH; i++) begin
            wait_ack(10, found, who, cyc);
            checks++;
            if (!found || who !== 1'b0) begin
                errors++;
                $display("FAIL fill_grant: read %0d found=%0b who=%0b required c0 grant", i, found, who);
            end
        end
        n = 0;
        repeat (8) begin
            @(negedge clk0_tb);
            if (c0_ack === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL full_blocks_read: acks=%0d required 0", n);
        end
        checks++;
        if (debug[4:3] !== 2'b01) begin
            errors++;
            $display("FAIL full_flag: debug=%0h required full set, empty clear", debug);
        end
        c1_req = 1'b1; c1_rnw = 1'b0; c1_addr = ADDR_W'(512);
        c1_wdata = {DATA_W'(16'h00bb), DATA_W'(16'h00aa)};
        wait_ack(10, found, who, cyc);
        c1_req = 1'b0;
        checks++;
        if (!found || who !== 1'b1 || w_data !== DATA_W'(16'h00aa)) begin
            errors++;
            $display("FAIL full_write_grant: found=%0b who=%0b w_data=%0h required c1 aa", found, who, w_data);
        end
        n = 0;
        repeat (6) begin
            @(negedge clk0_tb);
            if (c0_ack === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL full_still_blocked: acks=%0d required 0", n);
        end
        for (int k = 1; k <= 2; k++) begin
            rd_data_valid = 1'b1;
            rd_data_fifo_out = DATA_W'(100 + k);
            @(negedge clk0_tb);
            checks++;
            if (c0_rvalid !== 1'b1 || c0_rdata !== DATA_W'(100 + k)) begin
                errors++;
                $display("FAIL full_drain: rvalid=%0b rdata=%0h required 1 %0h", c0_rvalid, c0_rdata, 100 + k);
            end
        end
        rd_data_valid = 1'b0;
        wait_ack(10, found, who, cyc);
        c0_req = 1'b0;
        checks++;
        if (!found || who !== 1'b0) begin
            errors++;
            $display("FAIL full_release_grant: found=%0b who=%0b required c0", found, who);
        end
        for (int k = 0; k < 2 * TAG_DEPTH; k++) begin
            rd_data_valid = 1'b1;
            rd_data_fifo_out = DATA_W'(200 + k);
            @(negedge clk0_tb);
            checks++;
            if ({c1_rvalid, c0_rvalid} !== 2'b01 || c0_rdata !== DATA_W'(200 + k)) begin
                errors++;
                $display("FAIL drain_all: beat %0d rvalid c1c0=%0b%0b rdata=%0h", k, c1_rvalid, c0_rvalid, c0_rdata);
            end
        end
        rd_data_valid = 1'b0;
        repeat (2) @(negedge clk0_tb);
        checks++;
        if (debug[4] !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: debug=%0h required empty", debug);
        end
    endtask

    task automatic test_wdf_afull();
        bit found, who;
        int cyc, n;
        app_wdf_afull = 1'b1;
        c0_req = 1'b1; c0_rnw = 1'b0; c0_addr = ADDR_W'(768);
        c0_wdata = {DATA_W'(16'h0b0b), DATA_W'(16'h0a0a)};
        c1_req = 1'b1; c1_rnw = 1'b1; c1_addr = ADDR_W'(1024);
        wait_ack(10, found, who, cyc);
        c1_req = 1'b0;
        checks++;
        if (!found || who !== 1'b1 || cmd !== 3'b001 || address !== ADDR_W'(1024)) begin
            errors++;
            $display("FAIL afull_read_grant: found=%0b who=%0b cmd=%0h addr=%0d required c1 read 1024",
                     found, who, cmd, address);
        end
        n = 0;
        repeat (6) begin
            @(negedge clk0_tb);
            if (c0_ack === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL afull_blocks_write: acks=%0d required 0", n);
        end
        app_wdf_afull = 1'b0;
        wait_ack(10, found, who, cyc);
        c0_req = 1'b0;
        checks++;
        if (!found || who !== 1'b0 || wdf_we !== 1'b1 || w_data !== DATA_W'(16'h0a0a) || cmd !== 3'b000) begin
            errors++;
            $display("FAIL afull_write_grant: found=%0b who=%0b wdf_we=%0b w_data=%0h cmd=%0h",
                     found, who, wdf_we, w_data, cmd);
        end
        @(negedge clk0_tb);
        checks++;
        if (w_data !== DATA_W'(16'h0b0b) || af_we !== 1'b0 || wdf_we !== 1'b1) begin
            errors++;
            $display("FAIL afull_write_beat1: w_data=%0h af_we=%0b wdf_we=%0b required b0b 0 1", w_data, af_we, wdf_we);
        end
        for (int k = 0; k < 2; k++) begin
            rd_data_valid = 1'b1;
            rd_data_fifo_out = DATA_W'(300 + k);
            @(negedge clk0_tb);
            checks++;
            if ({c1_rvalid, c0_rvalid} !== 2'b10 || c1_rdata !== DATA_W'(300 + k)) begin
                errors++;
                $display("FAIL afull_return: beat %0d rvalid c1c0=%0b%0b rdata=%0h", k, c1_rvalid, c0_rvalid, c1_rdata);
            end
        end
        rd_data_valid = 1'b0;
        @(negedge clk0_tb);
    endtask

    task automatic test_orphan();
        checks++;
        if (debug[7] !== 1'b0 || debug[4] !== 1'b1) begin
            errors++;
            $display("FAIL orphan_pre: debug=%0h required orphan clear, empty set", debug);
        end
        rd_data_valid = 1'b1;
        rd_data_fifo_out = DATA_W'(16'hdead);
        @(negedge clk0_tb);
        rd_data_valid = 1'b0;
        checks++;
        if ({c1_rvalid, c0_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL orphan_dropped: rvalid c1c0=%0b%0b required 00", c1_rvalid, c0_rvalid);
        end
        repeat (3) @(negedge clk0_tb);
        checks++;
        if (debug[7] !== 1'b1 || debug[5] !== 1'b0) begin
            errors++;
            $display("FAIL orphan_sticky: debug=%0h required bit7 set, bp clear", debug);
        end
    endtask

    task automatic test_reset_mid_write();
        bit found, who;
        int cyc;
        c0_req = 1'b1; c0_rnw = 1'b0; c0_addr = ADDR_W'(90000);
        c0_wdata = {DATA_W'(4), DATA_W'(3)};
        wait_ack(10, found, who, cyc);
        c0_req = 1'b0;
        @(negedge clk0_tb);
        checks++;
        if (!found || wdf_we !== 1'b1 || w_data !== DATA_W'(4)) begin
            errors++;
            $display("FAIL midwrite_setup: found=%0b wdf_we=%0b w_data=%0h required 1 1 4", found, wdf_we, w_data);
        end
        #1 rst0_tb = 1'b1;
        #1;
        checks++;
        if ({cmd, address, af_we, wdf_we, w_data, c0_ack, c1_ack, c0_rvalid, c1_rvalid,
             c0_rdata, c1_rdata, debug} !== '0) begin
            errors++;
            $display("FAIL midwrite_reset: cmd=%0h af_we=%0b wdf_we=%0b w_data=%0h debug=%0h required all 0",
                     cmd, af_we, wdf_we, w_data, debug);
        end
        @(negedge clk0_tb);
        rst0_tb = 1'b0;
        repeat (2) @(negedge clk0_tb);
        checks++;
        if (debug !== 8'h10 || wdf_we !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_state: debug=%0h wdf_we=%0b required 10 0", debug, wdf_we);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rr();
        test_read_return();
        test_tag_full();
        test_wdf_afull();
        test_orphan();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
